// File: rtl/sram_req_master.sv
// sram_req_master: valid/ready requests to single-port SRAM cycles,
// fixed read-latency tracking, in-order response FIFO, init sweep.
module sram_req_master #(
   parameter int unsigned DATA_WIDTH = 64,
   parameter int unsigned NUM_WORDS = 1024,
   parameter int unsigned READ_LAT = 1,
   parameter int unsigned RSP_DEPTH = 2,
   parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0,
   parameter bit INIT_ON_RESET = 1'b0,
   localparam int unsigned AW = $clog2(NUM_WORDS),
   localparam int unsigned BEW = (DATA_WIDTH + 7) / 8
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  init_i,
   output logic                  init_busy_o,
   input  logic                  req_valid_i,
   output logic                  req_ready_o,
   input  logic                  req_we_i,
   input  logic [AW-1:0]         req_addr_i,
   input  logic [DATA_WIDTH-1:0] req_wdata_i,
   input  logic [BEW-1:0]        req_be_i,
   output logic                  rsp_valid_o,
   input  logic                  rsp_ready_i,
   output logic [DATA_WIDTH-1:0] rsp_rdata_o,
   output logic                  sram_req_o,
   output logic                  sram_we_o,
   output logic [AW-1:0]         sram_addr_o,
   output logic [DATA_WIDTH-1:0] sram_wdata_o,
   output logic [BEW-1:0]        sram_be_o,
   input  logic [DATA_WIDTH-1:0] sram_rdata_i
);

   localparam int unsigned CW = $clog2(RSP_DEPTH + 1);
   localparam int unsigned PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;

   typedef enum logic [1:0] {
      RUN,
      DRAIN,
      INIT
   } state_t;

   state_t state_q, state_d;
   logic [AW-1:0] cnt_q, cnt_d;
   logic [READ_LAT-1:0] pipe_q;
   logic [CW-1:0] inflight;
   logic [DATA_WIDTH-1:0] fifo_q [RSP_DEPTH];
   logic [PW-1:0] rd_ptr_q, wr_ptr_q;
   logic [CW-1:0] count_q;
   logic credit;
   logic rd_issue;
   logic push;
   logic pop;

   function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
      return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // count reads still travelling through the latency pipe
   always_comb begin
      inflight = '0;
      for (int i = 0; i < READ_LAT; i++)
         inflight = inflight + CW'(pipe_q[i]);
   end

   // registered counts only: a pop this cycle frees credit next cycle
   assign credit = (CW+1)'(inflight) + (CW+1)'(count_q)
                   < (CW+1)'(RSP_DEPTH);

   assign push = pipe_q[READ_LAT-1];
   assign pop = (count_q != '0) && rsp_ready_i;
   assign rsp_valid_o = (count_q != '0);
   assign rsp_rdata_o = fifo_q[rd_ptr_q];
   assign init_busy_o = (state_q != RUN);

   // next state and SRAM cycle generation; outputs forced idle in reset
   always_comb begin
      state_d = state_q;
      cnt_d = cnt_q;
      req_ready_o = 1'b0;
      sram_req_o = 1'b0;
      sram_we_o = 1'b0;
      sram_addr_o = '0;
      sram_wdata_o = '0;
      sram_be_o = '0;
      rd_issue = 1'b0;
      unique case (state_q)
         RUN: begin
            req_ready_o = credit;
            if (req_valid_i && credit) begin
               sram_req_o = 1'b1;
               sram_we_o = req_we_i;
               sram_addr_o = req_addr_i;
               sram_wdata_o = req_wdata_i;
               sram_be_o = req_we_i ? req_be_i : '1;
               rd_issue = ~req_we_i;
            end
            if (init_i)
               state_d = DRAIN;
         end
         DRAIN: begin
            if (inflight == '0) begin
               state_d = INIT;
               cnt_d = '0;
            end
         end
         INIT: begin
            sram_req_o = 1'b1;
            sram_we_o = 1'b1;
            sram_addr_o = cnt_q;
            sram_wdata_o = INIT_VALUE;
            sram_be_o = '1;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == AW'(NUM_WORDS - 1))
               state_d = RUN;
         end
         default: state_d = RUN;
      endcase
      if (rst_i) begin
         req_ready_o = 1'b0;
         sram_req_o = 1'b0;
         sram_we_o = 1'b0;
         sram_addr_o = '0;
         sram_wdata_o = '0;
         sram_be_o = '0;
         rd_issue = 1'b0;
      end
   end

   // state and sweep address registers
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= INIT_ON_RESET ? INIT : RUN;
         cnt_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q <= cnt_d;
      end
   end

   generate
      if (READ_LAT == 1) begin : g_lat1
         // one-stage read tag pipe
         always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i)
               pipe_q <= '0;
            else
               pipe_q <= rd_issue;
         end
      end else begin : g_latn
         // multi-stage read tag pipe
         always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i)
               pipe_q <= '0;
            else
               pipe_q <= {pipe_q[READ_LAT-2:0], rd_issue};
         end
      end
   endgenerate

   // response FIFO: capture returning read data, pop on handshake
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q <= '0;
         for (int i = 0; i < RSP_DEPTH; i++)
            fifo_q[i] <= '0;
      end else begin
         if (push) begin
            fifo_q[wr_ptr_q] <= sram_rdata_i;
            wr_ptr_q <= nxt(wr_ptr_q);
         end
         if (pop)
            rd_ptr_q <= nxt(rd_ptr_q);
         if (push && !pop)
            count_q <= count_q + 1'b1;
         else if (pop && !push)
            count_q <= count_q - 1'b1;
      end
   end

endmodule

// File: tb/tb_sram_req_master.sv
// tb_sram_req_master: directed + random stimulus against an SRAM model
// and a cycle-level scoreboard of the request/response behaviour.
module tb_sram_req_master;

   localparam int DW = 64;
   localparam int NW = 16;
   localparam int LAT = 2;
   localparam int DEPTH = 2;
   localparam int AW = 4;
   localparam int BEW = 8;
   localparam logic [DW-1:0] INITV = 64'hC0DE_0000_0000_BEEF;

   logic clk = 1'b0;
   logic rst_i = 1'b1;
   logic init_i = 1'b0;
   logic init_busy_o;
   logic req_valid_i = 1'b0;
   logic req_ready_o;
   logic req_we_i = 1'b0;
   logic [AW-1:0] req_addr_i = '0;
   logic [DW-1:0] req_wdata_i = '0;
   logic [BEW-1:0] req_be_i = '0;
   logic rsp_valid_o;
   logic rsp_ready_i = 1'b1;
   logic [DW-1:0] rsp_rdata_o;
   logic sram_req_o;
   logic sram_we_o;
   logic [AW-1:0] sram_addr_o;
   logic [DW-1:0] sram_wdata_o;
   logic [BEW-1:0] sram_be_o;
   logic [DW-1:0] sram_rdata_i;

   always #5 clk = ~clk;

   sram_req_master #(
      .DATA_WIDTH(DW),
      .NUM_WORDS(NW),
      .READ_LAT(LAT),
      .RSP_DEPTH(DEPTH),
      .INIT_VALUE(INITV),
      .INIT_ON_RESET(1'b0)
   ) dut (
      .clk_i(clk),
      .rst_i(rst_i),
      .init_i(init_i),
      .init_busy_o(init_busy_o),
      .req_valid_i(req_valid_i),
      .req_ready_o(req_ready_o),
      .req_we_i(req_we_i),
      .req_addr_i(req_addr_i),
      .req_wdata_i(req_wdata_i),
      .req_be_i(req_be_i),
      .rsp_valid_o(rsp_valid_o),
      .rsp_ready_i(rsp_ready_i),
      .rsp_rdata_o(rsp_rdata_o),
      .sram_req_o(sram_req_o),
      .sram_we_o(sram_we_o),
      .sram_addr_o(sram_addr_o),
      .sram_wdata_o(sram_wdata_o),
      .sram_be_o(sram_be_o),
      .sram_rdata_i(sram_rdata_i)
   );

   int checks = 0;
   int failures = 0;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // SRAM macro model with LAT-cycle read path; garbage when no read
   logic [DW-1:0] mem [NW];
   logic [DW-1:0] d1, d2;
   always @(posedge clk) begin
      if (sram_req_o && sram_we_o)
         for (int b = 0; b < BEW; b++)
            if (sram_be_o[b])
               mem[sram_addr_o][b*8 +: 8] <= sram_wdata_o[b*8 +: 8];
      if (sram_req_o && !sram_we_o)
         d1 <= mem[sram_addr_o];
      else
         d1 <= {$urandom, $urandom};
      d2 <= d1;
   end
   assign sram_rdata_i = d2;

   // reference model state
   typedef struct {
      logic [DW-1:0] data;
      int due;
   } exp_t;
   exp_t q[$];
   logic [DW-1:0] ref_mem [NW];
   logic [DW-1:0] got[$];
   int cyc = 0;
   int outstanding = 0;
   int last_rd = -100;
   int init_c = -100;
   int init_k = -100;
   bit init_pending = 1'b0;
   int npops = 0;
   int nreads = 0;
   bit in_busy, in_init, exp_ready, exp_v;
   logic exp_req, exp_we;
   logic [AW-1:0] exp_addr;
   logic [DW-1:0] exp_wdata;
   logic [BEW-1:0] exp_be;

   initial begin
      for (int i = 0; i < NW; i++) begin
         mem[i] = 64'h1111_0000_0000_0000 | 64'(i);
         ref_mem[i] = 64'h1111_0000_0000_0000 | 64'(i);
      end
   end

   always @(posedge clk) cyc <= cyc + 1;

   // per-cycle compare of all outputs against the model
   always @(negedge clk) begin
      if (rst_i) begin
         chk("rst_ctl", {req_ready_o, init_busy_o, rsp_valid_o,
                         sram_req_o, sram_we_o}, 0);
         chk("rst_rdata", rsp_rdata_o, 0);
         chk("rst_sram", {sram_addr_o, sram_be_o} | sram_wdata_o, 0);
         q.delete();
         outstanding = 0;
         last_rd = -100;
         init_pending = 1'b0;
      end else begin
         in_busy = init_pending && cyc >= init_c + 1 &&
                   cyc <= init_k + NW;
         in_init = init_pending && cyc >= init_k + 1 &&
                   cyc <= init_k + NW;
         exp_ready = !in_busy && outstanding < DEPTH;
         exp_req = 1'b0;
         exp_we = 1'b0;
         exp_addr = '0;
         exp_wdata = '0;
         exp_be = '0;
         if (in_init) begin
            exp_req = 1'b1;
            exp_we = 1'b1;
            exp_addr = AW'(cyc - init_k - 1);
            exp_wdata = INITV;
            exp_be = '1;
         end else if (req_valid_i && exp_ready) begin
            exp_req = 1'b1;
            exp_we = req_we_i;
            exp_addr = req_addr_i;
            exp_wdata = req_wdata_i;
            exp_be = req_we_i ? req_be_i : '1;
         end
         chk("req_ready", req_ready_o, exp_ready);
         chk("init_busy", init_busy_o, in_busy);
         chk("sram_req", sram_req_o, exp_req);
         chk("sram_we", sram_we_o, exp_we);
         chk("sram_addr", sram_addr_o, exp_addr);
         chk("sram_wdata", sram_wdata_o, exp_wdata);
         chk("sram_be", sram_be_o, exp_be);
         exp_v = q.size() > 0 && q[0].due <= cyc;
         chk("rsp_valid", rsp_valid_o, exp_v);
         if (exp_v)
            chk("rsp_rdata", rsp_rdata_o, q[0].data);
         if (rsp_valid_o && rsp_ready_i) begin
            got.push_back(rsp_rdata_o);
            npops++;
            if (q.size() > 0)
               void'(q.pop_front());
            outstanding--;
         end
         if (req_valid_i && req_ready_o) begin
            if (req_we_i) begin
               for (int b = 0; b < BEW; b++)
                  if (req_be_i[b])
                     ref_mem[req_addr_i][b*8 +: 8] = req_wdata_i[b*8 +: 8];
            end else begin
               q.push_back('{ref_mem[req_addr_i], cyc + LAT + 1});
               outstanding++;
               nreads++;
               last_rd = cyc;
            end
         end
         if (init_i && !in_busy) begin
            init_pending = 1'b1;
            init_c = cyc;
            init_k = (cyc + 1 > last_rd + LAT + 1) ? cyc + 1
                                                   : last_rd + LAT + 1;
            for (int i = 0; i < NW; i++)
               ref_mem[i] = INITV;
         end
      end
   end

   task automatic do_req(input bit we, input int a, input logic [DW-1:0] d,
                         input logic [BEW-1:0] be);
      bit ok;
      ok = 1'b0;
      req_valid_i = 1'b1;
      req_we_i = we;
      req_addr_i = AW'(a);
      req_wdata_i = d;
      req_be_i = be;
      for (int n = 0; n < 50 && !ok; n++) begin
         @(negedge clk);
         ok = req_ready_o;
         @(posedge clk);
         #1;
      end
      req_valid_i = 1'b0;
      if (!ok) begin
         checks++;
         failures++;
         $display("FAIL req_accept: got timeout expected accept addr %0d", a);
      end
   endtask

   task automatic wait_rsp(output int lat);
      lat = 0;
      for (int n = 1; n <= 12 && lat == 0; n++) begin
         @(negedge clk);
         if (rsp_valid_o)
            lat = n;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL global_timeout: got stuck expected finish");
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      int lat;
      int n;
      int p0;
      int g0;
      bit found;
      repeat (3) @(posedge clk);
      #1 rst_i = 1'b0;
      @(negedge clk);
      chk("post_rst_ready", req_ready_o, 1);
      @(posedge clk);
      #1;

      // write then read back, latency LAT+1 from accept
      do_req(1, 3, 64'hA5A5, '1);
      do_req(0, 3, '0, '0);
      wait_rsp(lat);
      chk("t1_lat", lat, 3);
      chk("t1_data", rsp_rdata_o, 64'hA5A5);
      repeat (2) @(posedge clk);
      #1;

      // byte-enable merge
      do_req(1, 5, '1, '1);
      do_req(1, 5, '0, 8'h01);
      do_req(0, 5, '0, '0);
      wait_rsp(lat);
      chk("t3_data", rsp_rdata_o, 64'hFFFF_FFFF_FFFF_FF00);
      repeat (2) @(posedge clk);
      #1;

      // credit exhaustion with consumer stalled
      p0 = npops;
      rsp_ready_i = 1'b0;
      do_req(0, 0, '0, '0);
      do_req(0, 1, '0, '0);
      req_valid_i = 1'b1;
      req_we_i = 1'b0;
      req_addr_i = 4'd2;
      @(negedge clk);
      chk("t2_full", req_ready_o, 0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("t2_full_hold", req_ready_o, 0);
      chk("t2_stall_valid", rsp_valid_o, 1);
      @(posedge clk);
      #1 rsp_ready_i = 1'b1;
      req_valid_i = 1'b0;
      do_req(0, 2, '0, '0);
      do_req(0, 3, '0, '0);
      repeat (10) @(posedge clk);
      #1;
      chk("t2_pops", npops - p0, 4);
      g0 = got.size() - 4;
      chk("t2_r0", got[g0], 64'h1111_0000_0000_0000);
      chk("t2_r1", got[g0+1], 64'h1111_0000_0000_0001);
      chk("t2_r2", got[g0+2], 64'h1111_0000_0000_0002);
      chk("t2_r3", got[g0+3], 64'hA5A5);

      // init requested together with a read
      g0 = got.size();
      req_valid_i = 1'b1;
      req_we_i = 1'b0;
      req_addr_i = 4'd2;
      init_i = 1'b1;
      @(negedge clk);
      chk("t4_ready", req_ready_o, 1);
      @(posedge clk);
      #1;
      req_valid_i = 1'b0;
      init_i = 1'b0;
      @(negedge clk);
      chk("t4_busy", init_busy_o, 1);
      chk("t4_block", req_ready_o, 0);
      n = 1;
      found = 1'b0;
      for (int i = 0; i < 100 && !found; i++) begin
         @(negedge clk);
         if (init_busy_o)
            n++;
         else
            found = 1'b1;
      end
      chk("t4_busy_len", n, 19);
      chk("t4_rsp_cnt", got.size() - g0, 1);
      chk("t4_rsp_data", got[g0], 64'h1111_0000_0000_0002);
      @(posedge clk);
      #1;
      do_req(0, 9, '0, '0);
      wait_rsp(lat);
      chk("t4_init_data", rsp_rdata_o, INITV);
      repeat (2) @(posedge clk);
      #1;

      // reset in the middle of a sweep; re-init pulse mid-sweep ignored
      init_i = 1'b1;
      @(posedge clk);
      #1 init_i = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         @(posedge clk);
         #1;
         init_i = init_busy_o && sram_addr_o == 4'd3;
         if (init_busy_o && sram_addr_o == 4'd7)
            found = 1'b1;
      end
      init_i = 1'b0;
      chk("t5_reach7", found, 1);
      rst_i = 1'b1;
      #1;
      chk("t5_rst_busy", init_busy_o, 0);
      chk("t5_rst_req", sram_req_o, 0);
      repeat (2) @(posedge clk);
      #1 rst_i = 1'b0;
      @(negedge clk);
      chk("t5_run_ready", req_ready_o, 1);
      chk("t5_run_busy", init_busy_o, 0);
      @(posedge clk);
      #1;

      // random traffic with random back-pressure
      for (int i = 0; i < 300; i++) begin
         req_valid_i = 1'($urandom_range(0, 1));
         req_we_i = ($urandom_range(0, 2) == 0);
         req_addr_i = AW'($urandom_range(0, NW - 1));
         req_wdata_i = {$urandom, $urandom};
         req_be_i = BEW'($urandom);
         rsp_ready_i = ($urandom_range(0, 3) != 0);
         @(posedge clk);
         #1;
      end
      req_valid_i = 1'b0;
      rsp_ready_i = 1'b1;
      repeat (12) @(posedge clk);
      @(negedge clk);
      chk("t6_drained", rsp_valid_o, 0);
      chk("t6_no_loss", npops, nreads);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
